// File: rtl/pwm_pkg.sv
// pwm_pkg: types and constants shared between the PWM generator and pwm_capture.
// Holds the capture FSM state enum, duty word width/full-scale value, the
// nominal period and a 3-input majority helper used by the optional glitch filter.
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } pwm_state_t;

  localparam int                PWM_PERIOD_DEFAULT = 255;
  localparam int                DUTY_W             = 8;
  localparam logic [DUTY_W-1:0] DUTY_FULL          = 8'hFF;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// pwm_edge_sync: brings the asynchronous PWM line into the clk domain and
// produces registered rise/fall pulses aligned with the level output `sync`.
// Ports: clk, rst (sync, active high), din (async line); sync (settled level),
// rise/fall (one-cycle pulses, asserted in the same cycle `sync` takes the new level).
// Macro PWM_CAP_GLITCH_FILTER_EN inserts a registered 3-tap majority filter,
// rejecting single-cycle pulses and adding 2 cycles of delay.
module pwm_edge_sync
  import pwm_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic s1, s2;
  logic lvl;
  logic prev;

  // Two-flop synchronizer.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

`ifdef PWM_CAP_GLITCH_FILTER_EN
  logic t1, t2, filt;

  // A level must persist on two of three consecutive samples to pass, so an
  // isolated one-cycle pulse never reaches the edge detector.
  always_ff @(posedge clk) begin
    if (rst) begin
      t1   <= 1'b0;
      t2   <= 1'b0;
      filt <= 1'b0;
    end else begin
      t1   <= s2;
      t2   <= t1;
      filt <= maj3(s2, t1, t2);
    end
  end

  assign lvl = filt;
`else
  assign lvl = s2;
`endif

  // Edge pulses are registered together with the previous-value register so
  // that `sync` (== prev) already shows the new level when the pulse is seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      prev <= lvl;
      rise <= lvl & ~prev;
      fall <= ~lvl & prev;
    end
  end

  assign sync = prev;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: recovers the 8-bit duty word from a PWM line made by the 8-bit
// generator (low for D cycles, high for PERIOD-D cycles; D=255 is constant low).
// Ports: CLK, RST (sync, active high), E (enable), PWM_IN (async line);
// D (duty), X (full scale), VALID (publish pulse), ERR (bad period pulse).
// VALID/ERR arrive 3 cycles after the falling edge is first sampled; with
// PWM_CAP_GLITCH_FILTER_EN defined a majority filter adds 2 cycles (5 total).
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int PERIOD = PWM_PERIOD_DEFAULT,
  parameter int TOL    = 2,
  parameter int CW     = 9
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              E,
  input  logic              PWM_IN,
  output logic [DUTY_W-1:0] D,
  output logic              X,
  output logic              VALID,
  output logic              ERR
);

  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
  localparam logic [CW-1:0] FULL_CNT  = CW'(DUTY_FULL);
  localparam logic [CW-1:0] RUN_LIMIT = CW'(PERIOD + TOL + 1);
  localparam logic [CW:0]   P_MIN     = (CW+1)'(PERIOD - TOL);
  localparam logic [CW:0]   P_MAX     = (CW+1)'(PERIOD + TOL);

  logic sync, rise, fall;

  pwm_edge_sync u_edge (
    .clk  (CLK),
    .rst  (RST),
    .din  (PWM_IN),
    .sync (sync),
    .rise (rise),
    .fall (fall)
  );

  pwm_state_t        state, state_nxt;
  logic [CW-1:0]     lo_cnt, lo_nxt;
  logic [CW-1:0]     hi_cnt, hi_nxt;
  logic [CW-1:0]     run_cnt, run_nxt, run_inc;
  logic [CW:0]       period;
  logic [DUTY_W-1:0] d_nxt;
  logic              x_nxt, valid_nxt, err_nxt;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + CW'(1);
  endfunction

  always_comb begin
    state_nxt = state;
    lo_nxt    = lo_cnt;
    hi_nxt    = hi_cnt;
    run_nxt   = run_cnt;
    d_nxt     = D;
    x_nxt     = X;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    period    = {1'b0, lo_cnt} + {1'b0, hi_cnt};
    run_inc   = sat_inc(run_cnt);

    if (!E) begin
      state_nxt = IDLE;
      lo_nxt    = '0;
      hi_nxt    = '0;
      run_nxt   = '0;
    end else if (rise || fall) begin
      // Any edge restarts the stuck-line timer; it also outranks a timeout
      // landing in the same cycle.
      run_nxt = '0;
      unique case (state)
        IDLE: begin
          if (fall) begin
            state_nxt = LOW;
            lo_nxt    = CW'(1);
            hi_nxt    = '0;
          end
        end
        LOW: begin
          if (rise) begin
            state_nxt = HIGH;
            hi_nxt    = CW'(1);
          end else begin
            lo_nxt = sat_inc(lo_cnt);
          end
        end
        HIGH: begin
          if (fall) begin
            // Full low+high period closed: publish if it is a plausible period.
            if (period >= P_MIN && period <= P_MAX) begin
              d_nxt     = (lo_cnt >= FULL_CNT) ? DUTY_FULL : lo_cnt[DUTY_W-1:0];
              x_nxt     = (lo_cnt >= FULL_CNT);
              valid_nxt = 1'b1;
            end else begin
              err_nxt = 1'b1;
            end
            state_nxt = LOW;
            lo_nxt    = CW'(1);
            hi_nxt    = '0;
          end else begin
            hi_nxt = sat_inc(hi_cnt);
          end
        end
        default: begin
          state_nxt = IDLE;
          lo_nxt    = '0;
          hi_nxt    = '0;
        end
      endcase
    end else if (run_inc == RUN_LIMIT) begin
      // No edge for a whole tolerated period: the line is stuck, which is how
      // the generator encodes the two extreme duty values.
      d_nxt     = sync ? '0 : DUTY_FULL;
      x_nxt     = ~sync;
      valid_nxt = 1'b1;
      run_nxt   = '0;
      state_nxt = IDLE;
      lo_nxt    = '0;
      hi_nxt    = '0;
    end else begin
      run_nxt = run_inc;
      if (state == LOW)  lo_nxt = sat_inc(lo_cnt);
      if (state == HIGH) hi_nxt = sat_inc(hi_cnt);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      lo_cnt  <= '0;
      hi_cnt  <= '0;
      run_cnt <= '0;
      D       <= '0;
      X       <= 1'b0;
      VALID   <= 1'b0;
      ERR     <= 1'b0;
    end else begin
      state   <= state_nxt;
      lo_cnt  <= lo_nxt;
      hi_cnt  <= hi_nxt;
      run_cnt <= run_nxt;
      D       <= d_nxt;
      X       <= x_nxt;
      VALID   <= valid_nxt;
      ERR     <= err_nxt;
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: self-checking bench for pwm_capture.
// A timestamp-based reference model runs alongside the DUT every cycle; a table
// of generator waveforms plus hand-written stuck-line, collision and reset
// sequences are checked against explicit expected values, followed by random periods.
module tb_pwm_capture;
  import pwm_pkg::*;

  localparam int PER   = 255;
  localparam int TOL   = 2;
  localparam int LIMIT = PER + TOL + 1;
`ifdef PWM_CAP_GLITCH_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  logic       CLK = 1'b0;
  logic       RST, E, PWM_IN;
  logic [7:0] D;
  logic       X, VALID, ERR;

  pwm_capture #(.PERIOD(PER), .TOL(TOL), .CW(9)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .E      (E),
    .PWM_IN (PWM_IN),
    .D      (D),
    .X      (X),
    .VALID  (VALID),
    .ERR    (ERR)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: history of sampled input (hist[0] newest) and the
  // timestamps of the last fall, last rise and last timer restart.
  logic       hist [8];
  int         t_fall = -1, t_rise = -1, last_evt = 0;
  logic [7:0] m_d = 8'd0;
  logic       m_x = 1'b0, m_valid = 1'b0, m_err = 1'b0;

  always @(posedge CLK) begin : model
    logic lvl, plvl;
    int   lo, p;
    cyc = cyc + 1;
    if (RST) begin
      for (int i = 0; i < 8; i++) hist[i] = 1'b0;
      t_fall = -1; t_rise = -1; last_evt = cyc;
      m_d = 8'd0; m_x = 1'b0; m_valid = 1'b0; m_err = 1'b0;
    end else begin
      for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = PWM_IN;
`ifdef PWM_CAP_GLITCH_FILTER_EN
      lvl  = (hist[4] & hist[5]) | (hist[4] & hist[6]) | (hist[5] & hist[6]);
      plvl = (hist[5] & hist[6]) | (hist[5] & hist[7]) | (hist[6] & hist[7]);
`else
      lvl  = hist[3];
      plvl = hist[4];
`endif
      m_valid = 1'b0;
      m_err   = 1'b0;
      if (!E) begin
        t_fall = -1; t_rise = -1; last_evt = cyc;
      end else if (lvl != plvl) begin
        last_evt = cyc;
        if (!lvl) begin
          if (t_fall >= 0 && t_rise > t_fall) begin
            lo = t_rise - t_fall;
            p  = cyc - t_fall;
            if (p >= PER - TOL && p <= PER + TOL) begin
              m_valid = 1'b1;
              m_d     = (lo >= 255) ? 8'd255 : 8'(lo);
              m_x     = (lo >= 255);
            end else begin
              m_err = 1'b1;
            end
          end
          t_fall = cyc; t_rise = -1;
        end else if (t_fall >= 0) begin
          t_rise = cyc;
        end
      end else if (cyc - last_evt == LIMIT) begin
        m_valid = 1'b1;
        m_d     = lvl ? 8'd0 : 8'd255;
        m_x     = ~lvl;
        last_evt = cyc; t_fall = -1; t_rise = -1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  int n_valid = 0, n_err = 0, last_valid_cyc = 0;

  always @(negedge CLK) begin
    chk("valid", {31'd0, VALID}, {31'd0, m_valid});
    chk("err",   {31'd0, ERR},   {31'd0, m_err});
    chk("d",     {24'd0, D},     {24'd0, m_d});
    chk("x",     {31'd0, X},     {31'd0, m_x});
    if (VALID) begin n_valid++; last_valid_cyc = cyc; end
    if (ERR) n_err++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic drive(input logic v, input int n);
    PWM_IN = v;
    tick(n);
  endtask

  task automatic wait_valid(input int v0, input int budget, input string tag);
    int k = 0;
    while (n_valid == v0 && k < budget) begin tick(1); k++; end
    if (n_valid == v0) begin
      checks++; errors++;
      $display("FAIL %s: no VALID within %0d cycles", tag, budget);
    end
  endtask

  typedef struct {
    int         lo;
    int         hi;
    bit         ok;
    logic [7:0] d;
    logic       x;
  } vec_t;

  localparam int NV = 13;
  vec_t tbl [NV];

  initial begin : watchdog
    #(10 * 90000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int v0, e0, fc, rc, t0, tgt, lo, hi;
    logic [7:0] hold_d;
    logic       hold_x;

    tbl[0]  = '{100, 155, 1'b1, 8'd100, 1'b0};
`ifdef PWM_CAP_GLITCH_FILTER_EN
    tbl[1]  = '{2,   253, 1'b1, 8'd2,   1'b0};
    tbl[5]  = '{253, 2,   1'b1, 8'd253, 1'b0};
`else
    tbl[1]  = '{1,   254, 1'b1, 8'd1,   1'b0};
    tbl[5]  = '{254, 1,   1'b1, 8'd254, 1'b0};
`endif
    tbl[2]  = '{2,   253, 1'b1, 8'd2,   1'b0};
    tbl[3]  = '{127, 128, 1'b1, 8'd127, 1'b0};
    tbl[4]  = '{253, 2,   1'b1, 8'd253, 1'b0};
    tbl[6]  = '{100, 200, 1'b0, 8'd0,   1'b0};   // period 300
    tbl[7]  = '{100, 150, 1'b0, 8'd0,   1'b0};   // period 250
    tbl[8]  = '{100, 153, 1'b1, 8'd100, 1'b0};   // period 253
    tbl[9]  = '{100, 157, 1'b1, 8'd100, 1'b0};   // period 257
    tbl[10] = '{100, 152, 1'b0, 8'd0,   1'b0};   // period 252
    tbl[11] = '{100, 158, 1'b0, 8'd0,   1'b0};   // period 258
    tbl[12] = '{255, 2,   1'b1, 8'd255, 1'b1};   // measured full scale

    RST = 1'b1; E = 1'b0; PWM_IN = 1'b0;
    tick(3);
    chk("rst_d", {24'd0, D}, 32'd0);
    chk("rst_x", {31'd0, X}, 32'd0);
    chk("rst_valid", {31'd0, VALID}, 32'd0);
    chk("rst_err", {31'd0, ERR}, 32'd0);
    RST = 1'b0;
    hold_d = 8'd0; hold_x = 1'b0;

    // Table of generator waveforms: three full periods each, closed by a fall.
    for (int i = 0; i < NV; i++) begin
      E = 1'b0; PWM_IN = 1'b1; tick(4);
      E = 1'b1; tick(LAT + 2);
      v0 = n_valid; e0 = n_err;
      for (int k = 0; k < 3; k++) begin
        drive(1'b0, tbl[i].lo);
        drive(1'b1, tbl[i].hi);
      end
      fc = cyc + 1;
      drive(1'b0, LAT + 3);
      if (tbl[i].ok) begin
        chk($sformatf("t%0d_nvalid", i), n_valid - v0, 32'd3);
        chk($sformatf("t%0d_nerr", i), n_err - e0, 32'd0);
        chk($sformatf("t%0d_d", i), {24'd0, D}, {24'd0, tbl[i].d});
        chk($sformatf("t%0d_x", i), {31'd0, X}, {31'd0, tbl[i].x});
        chk($sformatf("t%0d_latency", i), last_valid_cyc - fc, LAT);
        hold_d = tbl[i].d; hold_x = tbl[i].x;
      end else begin
        chk($sformatf("t%0d_nvalid", i), n_valid - v0, 32'd0);
        chk($sformatf("t%0d_nerr", i), n_err - e0, 32'd3);
        chk($sformatf("t%0d_dhold", i), {24'd0, D}, {24'd0, hold_d});
        chk($sformatf("t%0d_xhold", i), {31'd0, X}, {31'd0, hold_x});
      end
    end

    // Line stuck high after a rise: D=0 after LIMIT cycles, then every LIMIT.
    drive(1'b0, 100);
    rc = cyc + 1; PWM_IN = 1'b1;
    v0 = n_valid;
    wait_valid(v0, LIMIT + 40, "stuck_high");
    chk("stuck_high_time", last_valid_cyc - rc, LAT + LIMIT);
    chk("stuck_high_d", {24'd0, D}, 32'd0);
    chk("stuck_high_x", {31'd0, X}, 32'd0);
    v0 = n_valid; t0 = last_valid_cyc;
    wait_valid(v0, LIMIT + 40, "stuck_high_rep");
    chk("stuck_high_repeat", last_valid_cyc - t0, LIMIT);

    // Line stuck low: D=255, X=1.
    fc = cyc + 1; PWM_IN = 1'b0;
    v0 = n_valid;
    wait_valid(v0, LIMIT + 40, "stuck_low");
    chk("stuck_low_time", last_valid_cyc - fc, LAT + LIMIT);
    chk("stuck_low_d", {24'd0, D}, 32'd255);
    chk("stuck_low_x", {31'd0, X}, 32'd1);

    // Edge reaching the FSM in the very cycle the timeout would fire wins.
    t0  = last_valid_cyc;
    tgt = t0 + LIMIT - LAT - 1;
    while (cyc < tgt) tick(1);
    PWM_IN = 1'b1;
    v0 = n_valid;
    wait_valid(v0, 2 * LIMIT + 20, "collide");
    chk("collide_gap", last_valid_cyc - t0, 2 * LIMIT);
    chk("collide_d", {24'd0, D}, 32'd0);

    // Reset in the middle of a HIGH phase: partial period never published.
    drive(1'b0, 100);
    drive(1'b1, 50);
    RST = 1'b1; tick(1);
    chk("midrst_d", {24'd0, D}, 32'd0);
    chk("midrst_x", {31'd0, X}, 32'd0);
    chk("midrst_valid", {31'd0, VALID}, 32'd0);
    chk("midrst_err", {31'd0, ERR}, 32'd0);
    RST = 1'b0;
    v0 = n_valid; e0 = n_err;
    drive(1'b1, 105);
    drive(1'b0, LAT + 4);
    chk("midrst_nopub", n_valid - v0, 32'd0);
    chk("midrst_noerr", n_err - e0, 32'd0);
    drive(1'b0, 100 - (LAT + 4));
    drive(1'b1, 155);
    drive(1'b0, LAT + 3);
    chk("midrst_recover_n", n_valid - v0, 32'd1);
    chk("midrst_recover_d", {24'd0, D}, 32'd100);

`ifdef PWM_CAP_GLITCH_FILTER_EN
    // One-cycle high glitch in the low phase must be filtered out.
    v0 = n_valid; e0 = n_err;
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 40 - (k == 0 ? LAT + 3 : 0));
      drive(1'b1, 1);
      drive(1'b0, 59);
      drive(1'b1, 155);
    end
    fc = cyc + 1;
    drive(1'b0, LAT + 3);
    chk("glitch_n", n_valid - v0, 32'd2);
    chk("glitch_err", n_err - e0, 32'd0);
    chk("glitch_d", {24'd0, D}, 32'd100);
    chk("glitch_latency", last_valid_cyc - fc, LAT);
`endif

    // Random periods near nominal, occasional enable drops and stuck lines.
    for (int r = 0; r < 30; r++) begin
      lo = $urandom_range(1, 254);
      hi = 255 - lo + $urandom_range(0, 8) - 4;
      if (hi < 1) hi = 1;
      case ($urandom_range(0, 9))
        0: begin E = 1'b0; tick($urandom_range(1, 6)); E = 1'b1; end
        1: drive(1'b1, 300);
        default: ;
      endcase
      drive(1'b0, lo);
      drive(1'b1, hi);
    end
    drive(1'b0, LAT + 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Decoder counterpart to the team's 8-bit PWM generator used in the BLDC controller.
- Samples an incoming PWM line and recovers the 8-bit duty word D that produced it. The generator drives low for D cycles and high for PERIOD-D cycles; D=255 gives constant low.
- Used for loop-back verification of the generator and for reading externally generated PWM commands.
- Output is one validated duty word per PWM period, plus full-scale, error and valid flags.

Parameters:
- PERIOD, 255: nominal PWM period in CLK cycles.
- TOL, 2: accepted period deviation in cycles (±).
- CW, 9: width of the internal low, high and run counters; must satisfy 2^CW > PERIOD+TOL+1.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- RST  input  1  synchronous, active-high reset.
- E  input  1  enable; 0 holds the block idle.
- PWM_IN  input  1  asynchronous PWM line.
- D  output  8  recovered duty word.
- X  output  1  full-scale flag; 1 when the last published D came from a constant-low input.
- VALID  output  1  one-cycle pulse when D/X are updated.
- ERR  output  1  one-cycle pulse when a measured period falls outside PERIOD±TOL.

Behaviour:
- Reset (RST=1 on a CLK edge): D=0, X=0, VALID=0, ERR=0, state=IDLE, all counters 0, synchronizer flops 0. Reset overrides E and any measurement in progress; the partial period is discarded.
- Input path: 2-FF synchronizer, then a previous-value register. Rise = sync & ~prev; fall = ~sync & prev.
- E=0: state forced to IDLE, counters 0. D and X hold their last values; VALID=0, ERR=0.
- States:
  - IDLE: wait for fall, then go to LOW with lo_cnt=1.
  - LOW: lo_cnt++ each cycle. On rise, go to HIGH with hi_cnt=1.
  - HIGH: hi_cnt++ each cycle. On fall, evaluate the period (below), then return to LOW with lo_cnt=1.
- Period evaluation at fall: p = lo_cnt + hi_cnt, computed CW+1 bits wide.
  - If PERIOD-TOL <= p <= PERIOD+TOL: D = min(lo_cnt, 255), X = (lo_cnt >= 255), VALID=1.
  - Otherwise: ERR=1; D and X hold.
- Counters saturate at 2^CW-1 and never wrap.
- Run timeout: run_cnt counts cycles since the last edge of either polarity and clears on any edge. When run_cnt reaches PERIOD+TOL+1:
  - Synced level low: D=255, X=1, VALID=1 (matches generator D=255).
  - Synced level high: D=0, X=0, VALID=1 (matches generator D=0).
  - run_cnt then restarts at 0 and state goes to IDLE, so a stuck line republishes every PERIOD+TOL+1 cycles.
- Simultaneous timeout and edge in the same cycle: the edge wins and the timeout is suppressed.
- Latency: D/VALID/ERR are registered and update 3 CLK cycles after the PWM_IN falling edge is first sampled.
- The first VALID after reset or E rising requires one complete low-then-high period.

Optional Feature:
- Macro: PWM_CAP_GLITCH_FILTER_EN.
- Defined: a 3-tap majority filter sits after the synchronizer. Single-cycle pulses on PWM_IN are rejected, and all latencies grow by 2 cycles (3 becomes 5). Filter taps reset to 0.
- Undefined: no filter; edge detection runs directly on the synchronizer output.

Decomposition:
- Shared package pwm_pkg:
  - State enum (IDLE, LOW, HIGH).
  - PWM_PERIOD_DEFAULT = 255, DUTY_W = 8, DUTY_FULL = 8'hFF.
  - These are shared with the generator.
- Sub-module pwm_edge_sync: synchronizer, optional majority filter and rise/fall detection, with outputs sync, rise and fall. The FSM, counters and publish logic stay in pwm_capture.

Test Plan:
- Generator waveform D=100 (low 100, high 155), E=1: after the first full period, VALID every 255 cycles with D=100, X=0, ERR never asserted.
- Sweep D = 1, 2, 127, 253, 254: each decoded D equals the driven D after one period; VALID arrives 3 cycles after each falling edge.
- PWM_IN held high: VALID with D=0, X=0 at 258 cycles after the last edge, repeating every 258 cycles. PWM_IN held low: D=255, X=1.
- Periods of 300 (low 100, high 200) and 250 (low 100, high 150): ERR pulses, D holds its prior value, no VALID. Periods of 253 and 257: accepted.
- RST asserted in the middle of a HIGH phase: next-cycle outputs are all 0 and state is IDLE; the partial period is never published.
- With PWM_CAP_GLITCH_FILTER_EN, a 1-cycle high glitch inside the low phase of D=100: D=100 is still decoded, and latency is 5 cycles.
